ov7670_config_ctrl: RTL
=======================

OV7670_CONFIG_CTRL -- requirements
Module: ov7670_config_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 60, meaning i_clk cycles per SIOC quarter-period (24 MHz / 240 = 100 kHz).
REQ-002 SHALL have parameter RESET_WAIT_CYC, default 240000, meaning idle cycles after writing 16'h1280 (10 ms).
REQ-003 SHALL have parameter GAP_CYC, default 240, meaning idle cycles between ordinary writes.
REQ-004 SHALL have parameter MAX_REGS, default 255, meaning the write limit before the error state.
REQ-005 SHALL have parameter DEV_ID, default 8'h42, meaning the SCCB write address.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-007 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port i_start, input, 1 bit: one-cycle request to run the configuration.
REQ-009 SHALL have port o_config_start, output, 1 bit: one-cycle pulse that rewinds the register table.
REQ-010 SHALL have port o_next_reg, output, 1 bit: one-cycle pulse that advances the register table.
REQ-011 SHALL have port i_addr_data, input, 16 bits: the table entry, {reg addr, value}.
REQ-012 SHALL have port i_config_done, input, 1 bit: table terminator flag.
REQ-013 SHALL have port o_sioc, output, 1 bit: SCCB clock.
REQ-014 SHALL have port o_siod, output, 1 bit: SCCB data value.
REQ-015 SHALL have port o_siod_oe, output, 1 bit: SCCB data drive enable; the pad is released when 0.
REQ-016 SHALL have ports o_busy, o_done and o_err, outputs, 1 bit each: status.
REQ-017 SHALL have port o_reg_count, output, 8 bits: number of writes completed.

Function
REQ-018 SHALL implement states IDLE, REWIND, ROM_WAIT, CHECK, WRITE, DELAY, ADVANCE, DONE and ERR.
REQ-019 IDLE, DONE or ERR with i_start=1 SHALL go to REWIND; i_start in any other state SHALL be ignored.
REQ-020 REWIND SHALL assert o_config_start for exactly 1 cycle, clear o_reg_count, clear o_done and o_err, then enter ROM_WAIT.
REQ-021 ROM_WAIT SHALL hold for exactly 3 cycles, covering the table's index->data->done registered latency, then enter CHECK.
REQ-022 CHECK with i_config_done=1 or i_addr_data=16'hFFFF SHALL enter DONE.
REQ-023 CHECK with o_reg_count=MAX_REGS SHALL otherwise enter ERR.
REQ-024 CHECK SHALL otherwise latch i_addr_data and enter WRITE.
REQ-025 WRITE SHALL perform one 3-phase SCCB write: START, DEV_ID, addr[15:8], data[7:0], STOP.
REQ-026 Each SCCB phase SHALL be 9 bits, MSB first; the 9th bit is don't-care with o_siod_oe=0 and SHALL NOT be checked.
REQ-027 Every SCCB bit SHALL take 4 quarters of CLK_DIV cycles; SIOD changes only while SIOC is low; SIOC is high in quarters 2-3.
REQ-028 START SHALL drive SIOD 1->0 while SIOC=1 and then take SIOC low; STOP SHALL drive SIOD 0 with SIOC low, raise SIOC, then raise SIOD; each step lasts 1 quarter.
REQ-029 On WRITE completion o_reg_count SHALL increment, saturating at 255, and the block SHALL enter DELAY.
REQ-030 DELAY SHALL last RESET_WAIT_CYC cycles if the latched word is 16'h1280, otherwise GAP_CYC cycles, then enter ADVANCE.
REQ-031 ADVANCE SHALL assert o_next_reg for exactly 1 cycle, then enter ROM_WAIT.
REQ-032 o_busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-033 o_done SHALL be 1 only in DONE, and o_err SHALL be 1 only in ERR; both SHALL hold until the next i_start.
REQ-034 When not in WRITE, o_sioc SHALL be 1, o_siod SHALL be 1 and o_siod_oe SHALL be 1 (bus idle).

Reset
REQ-035 i_rst=1 SHALL immediately force state IDLE, o_sioc=1, o_siod=1, o_siod_oe=1, o_config_start=0, o_next_reg=0, o_busy=0, o_done=0, o_err=0, o_reg_count=0, and clear all counters.
REQ-036 Reset during an SCCB transfer SHALL abort it with no STOP generated; the next i_start SHALL restart from REWIND.

Structure
REQ-037 A shared package SHALL hold the state encoding, SCCB_ID=8'h42, TERM_WORD=16'hFFFF and RESET_WORD=16'h1280.
REQ-038 The SCCB bit/phase engine SHALL be a sub-module, sccb_write3, with a start/busy/done handshake, 8-bit id, 8-bit addr, 8-bit data and CLK_DIV; the controller instantiates it once.

Verification (CLK_DIV=2, RESET_WAIT_CYC=20, GAP_CYC=4, behavioural table model with 3-cycle latency)
REQ-039 Table {1280, 3A04, FFFF} with i_start -> 2 SCCB writes decoding to 42/12/80 and 42/3A/04; a 20-cycle gap after the first and 4 cycles after the second; o_reg_count=2; o_done=1; 2 o_next_reg pulses total.
REQ-040 SIOD monitor during every write -> no SIOD edge while SIOC=1 except at START/STOP; 9th bit of each phase has oe=0; each write is 27 bits plus START/STOP = 116 SIOC quarters.
REQ-041 i_rst asserted mid-phase of the second byte -> outputs idle the same cycle; a subsequent i_start yields o_config_start, then a complete write of entry 0.
REQ-042 Table with no terminator and MAX_REGS=3 -> 3 writes, then o_err=1, o_busy=0, no 4th START.
REQ-043 i_start pulsed while busy -> ignored, no extra o_config_start; i_start in DONE -> full rerun with o_reg_count reset to 0.
REQ-044 First entry FFFF -> o_done=1 with no SCCB activity and o_reg_count=0.

Source files
------------

// File: rtl/ov7670_config_ctrl_pkg.sv
// Shared definitions for the OV7670 SCCB configuration controller:
// state encodings and the fixed SCCB words.
package ov7670_config_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REWIND,
        ST_ROM_WAIT,
        ST_CHECK,
        ST_WRITE,
        ST_DELAY,
        ST_ADVANCE,
        ST_DONE,
        ST_ERR
    } cfg_state_t;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_START,
        SC_BITS,
        SC_STOP
    } sccb_state_t;

    localparam logic [7:0]  SCCB_ID    = 8'h42;
    localparam logic [15:0] TERM_WORD  = 16'hFFFF;
    localparam logic [15:0] RESET_WORD = 16'h1280;

endpackage

// File: rtl/ov7670_config_ctrl_sccb.sv
// SCCB 3-phase write engine: START, three 9-bit phases MSB first, STOP.
// Each step or bit lasts four quarters of CLK_DIV cycles.
module sccb_write3
    import ov7670_config_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_id,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_sioc,
    output logic       o_siod,
    output logic       o_siod_oe,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    sccb_state_t   state;
    logic [DW-1:0] div_cnt;
    logic [1:0]    quarter;
    logic [3:0]    bit_idx;
    logic [1:0]    phase;
    logic [23:0]   shreg;
    logic          q_end;

    assign q_end = (div_cnt == DW'(CLK_DIV - 1));

    // Bit quarters: 0 low (SIOD held), 1 low (SIOD updated), 2-3 high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= SC_IDLE;
            div_cnt   <= '0;
            quarter   <= '0;
            bit_idx   <= '0;
            phase     <= '0;
            shreg     <= '0;
            o_sioc    <= 1'b1;
            o_siod    <= 1'b1;
            o_siod_oe <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state == SC_IDLE) begin
                div_cnt <= '0;
                quarter <= '0;
                if (i_start) begin
                    state   <= SC_START;
                    o_busy  <= 1'b1;
                    shreg   <= {i_id, i_addr, i_data};
                    bit_idx <= '0;
                    phase   <= '0;
                end
            end else begin
                div_cnt <= q_end ? '0 : div_cnt + 1'b1;
                if (q_end) begin
                    quarter <= quarter + 2'd1;
                    case (state)
                        SC_START: begin
                            case (quarter)
                                2'd0:    o_siod <= 1'b0;
                                2'd1:    o_sioc <= 1'b0;
                                2'd3:    state  <= SC_BITS;
                                default: ;
                            endcase
                        end
                        SC_BITS: begin
                            case (quarter)
                                2'd0: begin
                                    if (bit_idx == 4'd8) begin
                                        o_siod_oe <= 1'b0;
                                    end else begin
                                        o_siod    <= shreg[23];
                                        o_siod_oe <= 1'b1;
                                    end
                                end
                                2'd1: o_sioc <= 1'b1;
                                2'd3: begin
                                    o_sioc <= 1'b0;
                                    if (bit_idx == 4'd8) begin
                                        bit_idx <= '0;
                                        if (phase == 2'd2) state <= SC_STOP;
                                        else phase <= phase + 2'd1;
                                    end else begin
                                        bit_idx <= bit_idx + 4'd1;
                                        shreg   <= {shreg[22:0], 1'b0};
                                    end
                                end
                                default: ;
                            endcase
                        end
                        SC_STOP: begin
                            case (quarter)
                                2'd0: begin
                                    o_siod    <= 1'b0;
                                    o_siod_oe <= 1'b1;
                                end
                                2'd1: o_sioc <= 1'b1;
                                2'd2: o_siod <= 1'b1;
                                default: begin
                                    state  <= SC_IDLE;
                                    o_busy <= 1'b0;
                                    o_done <= 1'b1;
                                end
                            endcase
                        end
                        default: state <= SC_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/ov7670_config_ctrl.sv
// OV7670 configuration sequencer: walks a registered register table and
// issues one SCCB write per entry, with a long settle after a soft reset.
module ov7670_config_ctrl
    import ov7670_config_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 60,
    parameter int unsigned RESET_WAIT_CYC = 240000,
    parameter int unsigned GAP_CYC        = 240,
    parameter int unsigned MAX_REGS       = 255,
    parameter logic [7:0]  DEV_ID         = SCCB_ID
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_config_start,
    output logic        o_next_reg,
    input  logic [15:0] i_addr_data,
    input  logic        i_config_done,
    output logic        o_sioc,
    output logic        o_siod,
    output logic        o_siod_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_reg_count
);

    cfg_state_t  state;
    logic [1:0]  wait_cnt;
    logic [31:0] dly_cnt;
    logic [31:0] dly_limit;
    logic [15:0] word;
    logic        eng_start;
    logic        eng_busy;
    logic        eng_done;

    always_comb dly_limit = (word == RESET_WORD) ? 32'(RESET_WAIT_CYC) : 32'(GAP_CYC);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            dly_cnt        <= '0;
            word           <= '0;
            eng_start      <= 1'b0;
            o_config_start <= 1'b0;
            o_next_reg     <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_reg_count    <= '0;
        end else begin
            o_config_start <= 1'b0;
            o_next_reg     <= 1'b0;
            eng_start      <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        state          <= ST_REWIND;
                        o_config_start <= 1'b1;
                        o_reg_count    <= '0;
                        o_done         <= 1'b0;
                        o_err          <= 1'b0;
                        o_busy         <= 1'b1;
                    end
                end
                ST_REWIND: begin
                    state    <= ST_ROM_WAIT;
                    wait_cnt <= '0;
                end
                ST_ROM_WAIT: begin
                    if (wait_cnt == 2'd2) state <= ST_CHECK;
                    else wait_cnt <= wait_cnt + 2'd1;
                end
                ST_CHECK: begin
                    if (i_config_done || i_addr_data == TERM_WORD) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else if ({24'd0, o_reg_count} == MAX_REGS) begin
                        state  <= ST_ERR;
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        word      <= i_addr_data;
                        eng_start <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (eng_done && !eng_busy) begin
                        if (o_reg_count != 8'hFF) o_reg_count <= o_reg_count + 8'd1;
                        dly_cnt <= '0;
                        state   <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt + 32'd1 >= dly_limit) begin
                        state      <= ST_ADVANCE;
                        o_next_reg <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 32'd1;
                    end
                end
                ST_ADVANCE: begin
                    state    <= ST_ROM_WAIT;
                    wait_cnt <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The engine idles with the bus released high, so its outputs drive the pads directly.
    sccb_write3 #(
        .CLK_DIV(CLK_DIV)
    ) u_sccb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (eng_start),
        .i_id     (DEV_ID),
        .i_addr   (word[15:8]),
        .i_data   (word[7:0]),
        .o_sioc   (o_sioc),
        .o_siod   (o_siod),
        .o_siod_oe(o_siod_oe),
        .o_busy   (eng_busy),
        .o_done   (eng_done)
    );

endmodule
